aes128_key_expander: RTL and testbench



---
 rtl/aes128_key_expander.sv | 111 +++++++++++
 tb/tb_aes128_key_expander.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/aes128_key_expander.sv
// aes128_key_expander: iterative AES-128 key schedule, one round per clock (optional EXPKEY_ZEROIZE_EN hides partial schedules)
module aes128_key_expander #(
    parameter int NR = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [127:0]    key,
    output logic [1407:0]   round_key_flat,
    output logic            key_expansion_done
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [127:0]       key_q, key_d;
    logic               loaded_q, loaded_d;
    logic               done_q, done_d;
    logic [NR:0][127:0] rk_q, rk_d;
    logic [127:0]       prev;
    logic [31:0]        rot, temp, n0, n1, n2, n3;
    logic               load;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as the GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s, r;
        s = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        return i == 4'd9 ? 8'h1b : i == 4'd10 ? 8'h36 : 8'(32'd1 << (i - 4'd1));
    endfunction

    assign load = !loaded_q || key != key_q;
    assign prev = rk_q[cnt_q - 4'd1];
    assign rot  = {prev[23:0], prev[31:24]};
    assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon(cnt_q), 24'h0};
    assign n0   = prev[127:96] ^ temp;
    assign n1   = prev[95:64] ^ n0;
    assign n2   = prev[63:32] ^ n1;
    assign n3   = prev[31:0] ^ n2;

    // Next state: a new or first key restarts from round 0, otherwise EXPAND fills one round per edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        loaded_d = loaded_q;
        done_d   = done_q;
        rk_d     = rk_q;
        if (load) begin
            key_d    = key;
            loaded_d = 1'b1;
            rk_d     = '0;
            rk_d[0]  = key;
            cnt_d    = 4'd1;
            done_d   = 1'b0;
            state_d  = EXPAND;
        end else if (state_q == EXPAND) begin
            rk_d[cnt_q] = {n0, n1, n2, n3};
            cnt_d       = cnt_q + 4'd1;
            if (cnt_q == 4'(NR)) begin
                done_d  = 1'b1;
                state_d = DONE;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            key_q    <= '0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            rk_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            rk_q     <= rk_d;
        end
    end

    assign key_expansion_done = done_q;
`ifdef EXPKEY_ZEROIZE_EN
    assign round_key_flat = done_q ? rk_q : '0;
`else
    assign round_key_flat = rk_q;
`endif

endmodule

// File: tb/tb_aes128_key_expander.sv
// tb_aes128_key_expander: directed and random key schedules checked against a word-level FIPS-197 model
module tb_aes128_key_expander;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [127:0]  key = '0;
    logic [1407:0] round_key_flat;
    logic          key_expansion_done;
    int            errors = 0;
    int            checks = 0;
    logic [7:0]    sbox_t[256];
    logic [127:0]  ka, kb;

    always #5 clk = ~clk;

    aes128_key_expander dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .round_key_flat(round_key_flat),
        .key_expansion_done(key_expansion_done)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic void build_sbox();
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = '0;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_t[x] = s;
        end
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w[44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] f;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) f[r * 128 +: 128] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return f;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk($sformatf("%s done", name), 128'(key_expansion_done), 128'(0));
        for (int r = 0; r < 11; r++)
            chk($sformatf("%s r%0d", name, r), round_key_flat[r * 128 +: 128], '0);
    endtask

    // Key already applied; walks the 11 edges from the load edge on
    task automatic expect_expansion(input logic [127:0] k, input string name);
        logic [1407:0] full = expand(k);
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk($sformatf("%s done@%0d", name, i), 128'(key_expansion_done), 128'(i == 11));
            for (int r = 0; r < 11; r++) begin
                logic [127:0] e;
                e = (r < i) ? full[r * 128 +: 128] : '0;
`ifdef EXPKEY_ZEROIZE_EN
                if (i != 11) e = '0;
`endif
                chk($sformatf("%s e%0d r%0d", name, i, r), round_key_flat[r * 128 +: 128], e);
            end
        end
    endtask

    task automatic run_key(input logic [127:0] k, input string name);
        @(negedge clk);
        key = k;
        expect_expansion(k, name);
    endtask

    task automatic hold(input int n, input string name);
        logic [1407:0] full = expand(key);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s hold done", name), 128'(key_expansion_done), 128'(1));
            for (int r = 0; r < 11; r++)
                chk($sformatf("%s hold r%0d", name, r), round_key_flat[r * 128 +: 128], full[r * 128 +: 128]);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        build_sbox();
        #1 rst = 1'b1;
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        expect_expansion('0, "zero");
        chk("zero r1", round_key_flat[128 +: 128], 128'h62636363626363636263636362636363);
        chk("zero r2", round_key_flat[256 +: 128], 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
        chk("zero r10", round_key_flat[1280 +: 128], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, "fips");
        chk("fips r1", round_key_flat[128 +: 128], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips r9", round_key_flat[1152 +: 128], 128'hac7766f319fadc2128d12941575c006e);
        chk("fips r10", round_key_flat[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        hold(4, "same");

        run_key({128{1'b1}}, "ones");
        chk("ones r1", round_key_flat[128 +: 128], 128'he8e9e9e917161616e8e9e9e917161616);
        chk("ones r10", round_key_flat[1280 +: 128], 128'hd60a3588e472f07b82d2d7858cd7c326);

        run_key(128'h0123456789abcdeffedcba9876543210, "seq");
        chk("seq r1", round_key_flat[128 +: 128], 128'h20008f5fa9ab42b05777f8282123ca38);
        chk("seq r10", round_key_flat[1280 +: 128], 128'hc55f24af238d91a058d4f5d551769ba7);

        ka = rnd128();
        kb = ~ka;
        @(negedge clk);
        key = ka;
        repeat (5) tick();
        chk("switch mid done", 128'(key_expansion_done), 128'(0));
        run_key(kb, "switch");
        hold(2, "switch");

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            key = rnd128();
            tick();
            chk($sformatf("churn done@%0d", i), 128'(key_expansion_done), 128'(0));
        end
        run_key(rnd128(), "after churn");

        ka = rnd128();
        @(negedge clk);
        key = ka;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1 chk_zero("rst mid");
        @(negedge clk);
        rst = 1'b0;
        expect_expansion(ka, "post rst");

        for (int i = 0; i < 5; i++) run_key(rnd128(), $sformatf("rand%0d", i));
        hold(3, "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
